// File: rtl/cmp_flag_unit_if.sv
// Operand and flag bundle between the condition-path issuer (master) and cmp_flag_unit (slave).
interface cmp_flag_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       flag_in;
    logic             en;
    logic [3:0]       new_flag;
    logic             flag_valid;

    modport master (
        output in1, in2, flag_in, en,
        input  new_flag, flag_valid
    );

    modport slave (
        input  in1, in2, flag_in, en,
        output new_flag, flag_valid
    );
endinterface

// File: rtl/cmp_flag_unit.sv
// Registered compare: flags {N,Z,C,V} of in1 - in2, or flag_in passthrough when en=0.
// One-cycle latency, one result per cycle, no backpressure.
module cmp_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    cmp_flag_unit_if.slave  bus
);
    logic [WIDTH:0] w_sum;
    logic           w_n;
    logic           w_z;
    logic           w_c;
    logic           w_v;
    logic [3:0]     w_cmp_flags;

    logic [3:0]     r_flag;
    logic           r_vld;

    // Subtract as in1 + ~in2 + 1 so the extra top bit is the ARM-style carry (1 = no borrow).
    assign w_sum = {1'b0, bus.in1} + {1'b0, ~bus.in2} + {{WIDTH{1'b0}}, 1'b1};

    assign w_n = w_sum[WIDTH-1];
    assign w_z = ~|w_sum[WIDTH-1:0];
    assign w_c = w_sum[WIDTH];
    assign w_v = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);

    assign w_cmp_flags = {w_n, w_z, w_c, w_v};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 4'b0000;
            r_vld  <= 1'b0;
        end else if (bus.en) begin
            r_flag <= w_cmp_flags;
            r_vld  <= 1'b1;
        end else begin
            r_flag <= bus.flag_in;
            r_vld  <= 1'b0;
        end
    end

    assign bus.new_flag   = r_flag;
    assign bus.flag_valid = r_vld;
endmodule

// File: tb/tb_cmp_flag_unit.sv
// Self-checking bench for cmp_flag_unit: directed boundary cases plus a randomized sweep against a relational model.
module tb_cmp_flag_unit;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    cmp_flag_unit_if #(.WIDTH(32)) bus ();

    cmp_flag_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference flags from arithmetic truth: exact signed difference and unsigned ordering.
    function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      d;
        logic [31:0] t;
        logic        n, z, c, v;
        sa = $signed(a);
        sb = $signed(b);
        d  = longint'(sa) - longint'(sb);
        t  = a - b;
        n  = t[31];
        z  = (a == b);
        c  = (a >= b);
        v  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
        return {n, z, c, v};
    endfunction

    // Expected condition outcomes taken directly from the operand relations.
    function automatic logic [7:0] ref_conds(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return {a == b, sa > sb, sa < sb, sa >= sb, sa <= sb, a > b, a < b, a >= b};
    endfunction

    // What the downstream evaluator would decode from a flag word: EQ GT LT GE LE HI LO HS.
    function automatic logic [7:0] decode(input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        return {z, !z && (n == v), n != v, n == v, z || (n != v), c && !z, !c, c};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7fff_ffff;
            3:       return 32'hffff_ffff;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic e, input logic [31:0] a, input logic [31:0] b, input logic [3:0] fi);
        bus.en      = e;
        bus.in1     = a;
        bus.in2     = b;
        bus.flag_in = fi;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] exp);
        drive(1'b1, a, b, 4'b0101);
        check({tag, "_flags"}, 8'(bus.new_flag), 8'(exp));
        check({tag, "_model"}, 8'(bus.new_flag), 8'(ref_flags(a, b)));
        check({tag, "_vld"}, 8'(bus.flag_valid), 8'h01);
    endtask

    initial begin
        logic        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fi;

        n_pass  = 0;
        n_total = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.in1     = '0;
        bus.in2     = '0;
        bus.flag_in = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 8'(bus.new_flag), 8'h00);
        check("reset_vld", 8'(bus.flag_valid), 8'h00);
        rst = 1'b0;

        cmp_step("eq_5_5", 32'd5, 32'd5, 4'b0110);
        cmp_step("lt_3_7", 32'd3, 32'd7, 4'b1000);
        cmp_step("m1_1", 32'hffff_ffff, 32'd1, 4'b1010);
        cmp_step("min_1", 32'h8000_0000, 32'd1, 4'b0011);
        cmp_step("max_m1", 32'h7fff_ffff, 32'hffff_ffff, 4'b1001);
        cmp_step("zero_min", 32'd0, 32'h8000_0000, 4'b1001);

        drive(1'b0, 32'd9, 32'd2, 4'b1011);
        check("pass_flags", 8'(bus.new_flag), 8'h0b);
        check("pass_vld", 8'(bus.flag_valid), 8'h00);

        drive(1'b1, 32'd10, 32'd4, 4'b1111);
        check("tog1_flags", 8'(bus.new_flag), 8'h02);
        check("tog1_vld", 8'(bus.flag_valid), 8'h01);
        drive(1'b0, 32'd10, 32'd4, 4'b0100);
        check("tog0_flags", 8'(bus.new_flag), 8'h04);
        check("tog0_vld", 8'(bus.flag_valid), 8'h00);
        drive(1'b1, 32'd4, 32'd10, 4'b0110);
        check("tog2_flags", 8'(bus.new_flag), 8'h08);
        check("tog2_vld", 8'(bus.flag_valid), 8'h01);

        // Asynchronous reset mid-cycle, held across an edge with en undefined.
        cmp_step("pre_rst", 32'd7, 32'd7, 4'b0110);
        #3 rst = 1'b1;
        #1;
        check("async_rst_flags", 8'(bus.new_flag), 8'h00);
        check("async_rst_vld", 8'(bus.flag_valid), 8'h00);
        bus.en = 1'bx;
        @(posedge clk);
        #1;
        check("rst_hold_flags", 8'(bus.new_flag), 8'h00);
        check("rst_hold_vld", 8'(bus.flag_valid), 8'h00);
        #2 rst = 1'b0;
        @(negedge clk);
        drive(1'b0, 32'd1, 32'd2, 4'b0101);
        check("post_rst_flags", 8'(bus.new_flag), 8'h05);
        check("post_rst_vld", 8'(bus.flag_valid), 8'h00);

        for (int i = 0; i < 12000; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            a  = pick();
            b  = ($urandom_range(0, 9) == 0) ? a : pick();
            fi = 4'($urandom());
            drive(e, a, b, fi);
            check("rnd_vld", 8'(bus.flag_valid), 8'(e));
            check("rnd_flags", 8'(bus.new_flag), 8'(e ? ref_flags(a, b) : fi));
            if (e) check("rnd_conds", decode(bus.new_flag), ref_conds(a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cmp_flag_unit.md
Name: cmp_flag_unit

Overview:
- Registered integer compare unit for the ALU condition path.
- Computes In1 − In2 and produces ARM-style condition flags [N, Z, C, V]; the subtraction result itself is not exposed.
- When the compare is not enabled, the incoming flag word passes through, so the flag register always holds the architecturally current flags.
- Feeds the conditional-execution evaluator, which decodes EQ/GT/LT/GE/LE/HI/LO/HS from these flags.

Parameters:
- WIDTH, 32, operand width in bits; operands are two's-complement signed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in1  input  WIDTH  minuend (signed).
- in2  input  WIDTH  subtrahend (signed).
- flag_in  input  4  current flags {N,Z,C,V}, bit3=N, bit2=Z, bit1=C, bit0=V.
- en  input  1  1 = perform compare this cycle; 0 = pass flag_in through.
- new_flag  output  4  registered flags {N,Z,C,V}.
- flag_valid  output  1  high for one cycle after any cycle with en=1.

Behaviour:
- Reset (asynchronous, active-high): new_flag=4'b0000 and flag_valid=0 immediately; both held while rst=1.
- Arithmetic: diff = in1 − in2, computed in WIDTH+1 bits as in1 + ~in2 + 1 to obtain the carry-out.
  - N = diff[WIDTH−1].
  - Z = 1 iff diff[WIDTH−1:0]==0.
  - C = carry-out of in1 + ~in2 + 1, i.e. 1 iff in1 ≥ in2 as unsigned values (no borrow).
  - V = 1 iff in1[MSB] != in2[MSB] and diff[MSB] != in1[MSB] (signed overflow).
- Latency: one clock. Operands and en sampled at rising edge N; new_flag shows the result after edge N until the next update.
- en=1 at edge: new_flag <= {N,Z,C,V}; flag_in is ignored; flag_valid <= 1.
- en=0 at edge: new_flag <= flag_in unchanged; flag_valid <= 0.
- All four flags are always updated together; no partial flag writes.
- Back-to-back en=1 cycles give one new result per cycle; flag_valid stays high continuously.
- Reset deasserted mid-stream: the first edge after release behaves normally per en; no pipeline residue remains.
- X/undefined en during reset has no effect.
- Boundary results:
  - in1=in2 gives Z=1, C=1, N=0, V=0.
  - in1=most-negative, in2=1 gives V=1.
  - in1=0, in2=most-negative gives V=1, N=1.
- Downstream decode that this block must satisfy:
  - EQ: Z.
  - GT: !Z && N==V.
  - LT: N!=V.
  - GE: N==V.
  - LE: Z || N!=V.
  - HI: C && !Z.
  - LO: !C.
  - HS: C.

Test Plan:
- Assert rst with new_flag nonzero, asynchronously mid-cycle -> new_flag=0000, flag_valid=0 immediately, before the next edge.
- en=1, in1=5, in2=5 -> after one edge new_flag=0110 (Z=1, C=1), flag_valid=1.
- en=1, in1=3, in2=7 -> new_flag=1000 (N=1, C=0 borrow, V=0); then in1=−1 (0xFFFFFFFF), in2=1 -> new_flag=1010 (N=1, C=1 unsigned higher, V=0).
- en=1, in1=0x80000000, in2=1 -> new_flag=0011 (N=0, Z=0, C=1, V=1); in1=0x7FFFFFFF, in2=0xFFFFFFFF -> new_flag=1001 (N=1, C=0, V=1).
- en=0, flag_in=1011, operands arbitrary -> new_flag=1011 after edge, flag_valid=0; toggle en=1,0,1 with differing operands -> flag_valid=1,0,1 and flags alternate correctly each cycle.
- Random signed operand sweep (≥10k vectors) -> new_flag matches a reference model of N/Z/C/V and the derived EQ/GT/LT/GE/LE/HI/LO/HS decodes, with a one-cycle lag.
